// File: rtl/rock_intensity_ctrl.sv
// -----------------------------------------------------------------------------
// rock_intensity_ctrl
// Drives the cradle rocking intensity from the heart-rate sample (hart) and the
// heart-rate-settled flag (gedaald) produced by the settle detector.
// Rocking ramps up one level per slow sample while the baby is stressed. It
// holds once the rate settles, then steps down to rest and pulses done.
//
// Optional feature macro: ROCK_WATCHDOG_EN
//   When defined, a watchdog watches for too long at full intensity and forces
//   a FAULT state (intensity 0, alarm 1). The FAULT state persists until reset
//   or until enable drops. When undefined, alarm is tied to 0.
//
// Ports
//   slow      in   1  sample clock, rising edge
//   reset     in   1  synchronous, active-high
//   enable    in   1  controller enable; low forces IDLE next cycle
//   hart      in   6  current heart-rate sample
//   gedaald   in   1  heart rate settled flag
//   intensity out  3  rocking level, 0 = stopped (registered)
//   rocking   out  1  intensity != 0 (registered)
//   done      out  1  one-cycle pulse when an episode ends normally
//   alarm     out  1  watchdog fault
// -----------------------------------------------------------------------------
module rock_intensity_ctrl #(
  parameter int HART_THRESH   = 40,
  parameter int MAX_LEVEL     = 7,
  parameter int HOLD_CYCLES   = 8,
  parameter int SETTLE_CYCLES = 4
`ifdef ROCK_WATCHDOG_EN
  ,
  parameter int WATCHDOG_CYCLES = 32
`endif
) (
  input  logic       slow,
  input  logic       reset,
  input  logic       enable,
  input  logic [5:0] hart,
  input  logic       gedaald,
  output logic [2:0] intensity,
  output logic       rocking,
  output logic       done,
  output logic       alarm
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RAMP   = 3'd1;
  localparam logic [2:0] HOLD   = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
`ifdef ROCK_WATCHDOG_EN
  localparam logic [2:0] FAULT  = 3'd4;
`endif

  localparam int CNT_MAX = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [2:0] LEVEL_MAX = 3'(MAX_LEVEL);
  localparam logic [5:0] THRESH    = 6'(HART_THRESH);

  logic [2:0]       state_r, state_s;
  logic [2:0]       intensity_r, intensity_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             done_r, done_s;
  logic             rocking_r;
  logic             stressed_s;
  logic [2:0]       level_up_s;
  logic [2:0]       level_dn_s;

`ifdef ROCK_WATCHDOG_EN
  localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0] WD_ZERO  = {WD_W{1'b0}};
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);
  logic [WD_W-1:0] wd_r, wd_s;
  logic            alarm_r, alarm_s;
`endif

  assign stressed_s = (hart > THRESH);
  // Saturating step-up, and a step-down that can never underflow.
  assign level_up_s = (intensity_r == LEVEL_MAX) ? intensity_r : (intensity_r + 3'd1);
  assign level_dn_s = (intensity_r != 3'd0) ? (intensity_r - 3'd1) : 3'd0;

  // Next-state, next-intensity, countdown and done-pulse computation.
  always_comb begin
    state_s     = state_r;
    intensity_s = intensity_r;
    cnt_s       = cnt_r;
    done_s      = 1'b0;
`ifdef ROCK_WATCHDOG_EN
    wd_s        = WD_ZERO;
    alarm_s     = 1'b0;
`endif
    if (!enable) begin
      // Disable aborts any episode silently: no done pulse, alarm cleared.
      state_s     = IDLE;
      intensity_s = 3'd0;
      cnt_s       = CNT_ZERO;
    end else begin
`ifdef ROCK_WATCHDOG_EN
      // Count consecutive cycles spent pushing at full level.
      if (((state_r == RAMP) || (state_r == HOLD)) && (intensity_r == LEVEL_MAX)) begin
        wd_s = wd_r + WD_ONE;
      end else begin
        wd_s = WD_ZERO;
      end
      if (wd_s == WD_LIMIT) begin
        state_s     = FAULT;
        intensity_s = 3'd0;
        cnt_s       = CNT_ZERO;
        alarm_s     = 1'b1;
        wd_s        = WD_ZERO;
      end else
`endif
      begin
        case (state_r)
          IDLE: begin
            if (stressed_s) begin
              state_s     = RAMP;
              intensity_s = 3'd1;
            end else begin
              intensity_s = 3'd0;
            end
          end
          RAMP: begin
            if (gedaald) begin
              state_s = HOLD;
              cnt_s   = HOLD_LOAD;
            end else begin
              intensity_s = level_up_s;
            end
          end
          HOLD: begin
            if (!gedaald) begin
              state_s = RAMP;
            end else if (cnt_r == CNT_ZERO) begin
              // Leaving HOLD always takes the first step down; from level 1
              // that already ends the episode.
              if (level_dn_s == 3'd0) begin
                state_s     = IDLE;
                intensity_s = 3'd0;
                cnt_s       = CNT_ZERO;
                done_s      = 1'b1;
              end else begin
                state_s     = SETTLE;
                intensity_s = level_dn_s;
                cnt_s       = SETTLE_LOAD;
              end
            end else begin
              cnt_s = cnt_r - CNT_ONE;
            end
          end
          SETTLE: begin
            // Renewed stress wins over a pending step-down.
            if (!gedaald && stressed_s) begin
              state_s = RAMP;
            end else if (cnt_r == CNT_ZERO) begin
              if (level_dn_s == 3'd0) begin
                state_s     = IDLE;
                intensity_s = 3'd0;
                cnt_s       = CNT_ZERO;
                done_s      = 1'b1;
              end else begin
                intensity_s = level_dn_s;
                cnt_s       = SETTLE_LOAD;
              end
            end else begin
              cnt_s = cnt_r - CNT_ONE;
            end
          end
`ifdef ROCK_WATCHDOG_EN
          FAULT: begin
            intensity_s = 3'd0;
            alarm_s     = 1'b1;
          end
`endif
          default: begin
            state_s     = IDLE;
            intensity_s = 3'd0;
            cnt_s       = CNT_ZERO;
          end
        endcase
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge slow) begin
    if (reset) begin
      state_r     <= IDLE;
      intensity_r <= 3'd0;
      cnt_r       <= CNT_ZERO;
      done_r      <= 1'b0;
      rocking_r   <= 1'b0;
`ifdef ROCK_WATCHDOG_EN
      wd_r        <= WD_ZERO;
      alarm_r     <= 1'b0;
`endif
    end else begin
      state_r     <= state_s;
      intensity_r <= intensity_s;
      cnt_r       <= cnt_s;
      done_r      <= done_s;
      rocking_r   <= (intensity_s != 3'd0);
`ifdef ROCK_WATCHDOG_EN
      wd_r        <= wd_s;
      alarm_r     <= alarm_s;
`endif
    end
  end

  assign intensity = intensity_r;
  assign rocking   = rocking_r;
  assign done      = done_r;
`ifdef ROCK_WATCHDOG_EN
  assign alarm     = alarm_r;
`else
  assign alarm     = 1'b0;
`endif

endmodule

// File: tb/tb_rock_intensity_ctrl.sv
// Scoreboard bench for rock_intensity_ctrl: a driver applies directed and
// random stimulus on the falling edge, runs a behavioural model and queues the
// expected outputs; a monitor pops and compares after every rising edge.
module tb_rock_intensity_ctrl;

  logic       slow = 1'b0;
  logic       reset;
  logic       enable;
  logic [5:0] hart;
  logic       gedaald;
  logic [2:0] intensity;
  logic       rocking;
  logic       done;
  logic       alarm;

  rock_intensity_ctrl dut (
    .slow      (slow),
    .reset     (reset),
    .enable    (enable),
    .hart      (hart),
    .gedaald   (gedaald),
    .intensity (intensity),
    .rocking   (rocking),
    .done      (done),
    .alarm     (alarm)
  );

  always #5 slow = ~slow;

  // Behavioural model: episode phase, current level, remaining cycles in the
  // present hold/ease window, and time spent at full level.
  typedef enum int {M_REST, M_CLIMB, M_HOLD, M_EASE, M_FAULT} mode_t;
  mode_t m_mode  = M_REST;
  int    m_level = 0;
  int    m_timer = 0;
  int    m_wd    = 0;
  bit    m_done  = 1'b0;
  bit    m_alarm = 1'b0;

  logic [5:0] exp_q[$];
  int compared   = 0;
  int mismatched = 0;

  task automatic model_step(input bit r, input bit en, input int h, input bit g);
    bit stressed;
    stressed = (h > 40);
    m_done   = 1'b0;
    if (r || !en) begin
      m_mode  = M_REST;
      m_level = 0;
      m_timer = 0;
      m_wd    = 0;
      m_alarm = 1'b0;
      return;
    end
`ifdef ROCK_WATCHDOG_EN
    if ((m_mode == M_CLIMB || m_mode == M_HOLD) && m_level == 7) m_wd = m_wd + 1;
    else m_wd = 0;
    if (m_wd == 32) begin
      m_mode  = M_FAULT;
      m_level = 0;
      m_alarm = 1'b1;
      m_wd    = 0;
      return;
    end
`endif
    case (m_mode)
      M_REST: begin
        if (stressed) begin
          m_mode  = M_CLIMB;
          m_level = 1;
        end
      end
      M_CLIMB: begin
        if (g) begin
          m_mode  = M_HOLD;
          m_timer = 8;
        end else if (m_level < 7) begin
          m_level = m_level + 1;
        end
      end
      M_HOLD, M_EASE: begin
        if (m_mode == M_HOLD && !g) begin
          m_mode = M_CLIMB;
        end else if (m_mode == M_EASE && !g && stressed) begin
          m_mode = M_CLIMB;
        end else begin
          m_timer = m_timer - 1;
          if (m_timer == 0) begin
            m_level = m_level - 1;
            if (m_level == 0) begin
              m_mode = M_REST;
              m_done = 1'b1;
            end else begin
              m_mode  = M_EASE;
              m_timer = 4;
            end
          end
        end
      end
      M_FAULT: begin
        m_level = 0;
        m_alarm = 1'b1;
      end
      default: m_mode = M_REST;
    endcase
  endtask

  task automatic drive(input bit r, input bit en, input int h, input bit g);
    @(negedge slow);
    reset   = r;
    enable  = en;
    hart    = h[5:0];
    gedaald = g;
    model_step(r, en, h, g);
    exp_q.push_back({m_level[2:0], (m_level != 0), m_done, m_alarm});
  endtask

  // Monitor: one expected output word per rising edge once stimulus has begun.
  always @(posedge slow) begin : monitor
    logic [5:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      compared++;
      if ({intensity, rocking, done, alarm} !== e) begin
        mismatched++;
        $display("FAIL outputs t=%0t: got intensity=%0d rocking=%0b done=%0b alarm=%0b, expected intensity=%0d rocking=%0b done=%0b alarm=%0b",
                 $time, intensity, rocking, done, alarm, e[5:3], e[2], e[1], e[0]);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    hart    = 6'd0;
    gedaald = 1'b0;

    // Reset held while enabled and stressed, then released with enable low.
    repeat (3) drive(1'b1, 1'b1, 60, 1'b0);
    drive(1'b0, 1'b0, 60, 1'b0);
    // Threshold boundary: 40 is not stressed, 41 is.
    repeat (2) drive(1'b0, 1'b1, 40, 1'b0);
    drive(1'b0, 1'b1, 41, 1'b0);
    // Ramp to saturation.
    repeat (10) drive(1'b0, 1'b1, 50, 1'b0);
    drive(1'b0, 1'b0, 50, 1'b0);
    // Hold at 3 then settle down to rest with done.
    repeat (3) drive(1'b0, 1'b1, 50, 1'b0);
    repeat (20) drive(1'b0, 1'b1, 20, 1'b1);
    // HOLD interrupted at 5, then SETTLE interrupted by renewed stress.
    repeat (5) drive(1'b0, 1'b1, 50, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 20, 1'b1);
    repeat (2) drive(1'b0, 1'b1, 50, 1'b0);
    repeat (10) drive(1'b0, 1'b1, 20, 1'b1);
    repeat (2) drive(1'b0, 1'b1, 45, 1'b0);
    drive(1'b0, 1'b0, 45, 1'b0);
    // Disable mid-ramp at 4, re-enable with a calm rate.
    repeat (4) drive(1'b0, 1'b1, 50, 1'b0);
    drive(1'b0, 1'b0, 50, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 30, 1'b0);
    // Settle entry from level 1 ends the episode directly.
    drive(1'b0, 1'b1, 50, 1'b0);
    repeat (10) drive(1'b0, 1'b1, 10, 1'b1);
    // Long stay at full level (watchdog path when enabled), then disable.
    repeat (48) drive(1'b0, 1'b1, 63, 1'b0);
    drive(1'b0, 1'b0, 63, 1'b0);
    // Reset mid-episode.
    repeat (3) drive(1'b0, 1'b1, 55, 1'b0);
    drive(1'b1, 1'b1, 55, 1'b0);

    // Random segments with steady input classes so holds and settles complete.
    for (int s = 0; s < 300; s++) begin
      int len;
      bit en;
      bit g;
      bit st;
      bit r;
      len = $urandom_range(1, 12);
      en  = ($urandom_range(0, 15) != 0);
      g   = $urandom_range(0, 1);
      st  = $urandom_range(0, 1);
      r   = ($urandom_range(0, 60) == 0);
      for (int c = 0; c < len; c++) begin
        int h;
        h = st ? $urandom_range(41, 63) : $urandom_range(0, 40);
        drive(r && (c == 0), en, h, g);
      end
    end

    @(posedge slow);
    #3;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected outputs left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
